// File: rtl/frog_move_sched_if.sv
// Move-command handshake between the move scheduler (master) and the
// frog position logic (slave).
interface frog_move_sched_if;
   logic       move_valid;
   logic       move_ready;
   logic [1:0] move_dir;
   logic       repeating;

   modport master (output move_valid, move_dir, repeating, input move_ready);
   modport slave  (input move_valid, move_dir, repeating, output move_ready);
endinterface

// File: rtl/frog_move_sched.sv
// Turns debounced direction buttons into single frog move commands, with
// fixed-priority arbitration and hold-to-auto-repeat.
//
// state | meaning
// IDLE  | no move pending, waiting for a fresh press tick
// ISSUE | move_valid high, waiting for the consumer to accept
// HOLD  | move accepted, button still held, counting down to the next repeat
module frog_move_sched #(
   parameter int HOLD_DELAY    = 25000000,
   parameter int REPEAT_PERIOD = 10000000,
   parameter int CW            = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            btn_level,
   input  logic [3:0]            btn_tick,
   input  logic                  enable,
   frog_move_sched_if.master     mv
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_DELAY - 1);
   localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_PERIOD - 1);

   state_t        state, state_n;
   logic [1:0]    dir, dir_n;
   logic          valid, valid_n;
   logic          rep, rep_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    other_tick;

   function automatic logic [1:0] win(input logic [3:0] t);
      if (t[0])      win = 2'd0;
      else if (t[1]) win = 2'd1;
      else if (t[2]) win = 2'd2;
      else           win = 2'd3;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         dir   <= 2'd0;
         valid <= 1'b0;
         rep   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         dir   <= dir_n;
         valid <= valid_n;
         rep   <= rep_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      dir_n      = dir;
      valid_n    = valid;
      rep_n      = rep;
      cnt_n      = cnt;
      other_tick = btn_tick & ~(4'b0001 << dir);

      if (!enable) begin
         state_n = IDLE;
         valid_n = 1'b0;
         rep_n   = 1'b0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (|btn_tick) begin
                  dir_n   = win(btn_tick);
                  valid_n = 1'b1;
                  rep_n   = 1'b0;
                  state_n = ISSUE;
               end
            end
            ISSUE: begin
               if (valid && mv.move_ready) begin
                  valid_n = 1'b0;
                  rep_n   = 1'b0;
                  if (btn_level[dir]) begin
                     state_n = HOLD;
                     cnt_n   = rep ? REP_LOAD : HOLD_LOAD;
                  end else begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end
               end
            end
            HOLD: begin
               cnt_n = (cnt != '0) ? cnt - 1'b1 : '0;
               // A new direction preempts even if the held button is released in the same cycle.
               if (|other_tick) begin
                  dir_n   = win(other_tick);
                  valid_n = 1'b1;
                  rep_n   = 1'b0;
                  cnt_n   = '0;
                  state_n = ISSUE;
               end else if (!btn_level[dir]) begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end else if (cnt <= CW'(1)) begin
                  // Raise valid on the edge where the count reaches zero so the
                  // press-to-press spacing is exactly the configured period.
                  valid_n = 1'b1;
                  rep_n   = 1'b1;
                  cnt_n   = '0;
                  state_n = ISSUE;
               end
            end
            default: begin
               state_n = IDLE;
               valid_n = 1'b0;
               rep_n   = 1'b0;
               cnt_n   = '0;
            end
         endcase
      end
   end

   assign mv.move_valid = valid;
   assign mv.move_dir   = dir;
   assign mv.repeating  = rep;

endmodule

// File: tb/tb_frog_move_sched.sv
// Scoreboard bench for frog_move_sched: stimulus pushes expected moves,
// a negedge monitor pops and compares on every accepted move.
module tb_frog_move_sched;

   localparam int HD = 8;
   localparam int RP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_level;
   logic [3:0] btn_tick;
   logic       enable;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   typedef struct {
      logic [1:0] dir;
      logic       rep;
      int         cyc;
   } exp_t;

   exp_t q[$];

   frog_move_sched_if mif ();

   frog_move_sched #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .CW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_level (btn_level),
      .btn_tick  (btn_tick),
      .enable    (enable),
      .mv        (mif.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] d, input logic r, input int c);
      exp_t e;
      e.dir = d;
      e.rep = r;
      e.cyc = c;
      q.push_back(e);
   endtask

   // Monitor: checks hold stability while stalled and scores every accept.
   logic       prev_pend = 1'b0;
   logic [1:0] prev_dir  = 2'd0;
   logic       prev_rep  = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_pend && mif.move_valid) begin
            chk("stall_dir_stable", int'(mif.move_dir), int'(prev_dir));
            chk("stall_rep_stable", int'(mif.repeating), int'(prev_rep));
         end
         if (mif.move_valid && mif.move_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_move_dir", int'(mif.move_dir), -1);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("move_dir", int'(mif.move_dir), int'(e.dir));
               chk("move_repeating", int'(mif.repeating), int'(e.rep));
               chk("move_cycle", cyc, e.cyc);
            end
         end
         prev_pend <= mif.move_valid && !mif.move_ready;
         prev_dir  <= mif.move_dir;
         prev_rep  <= mif.repeating;
      end else begin
         prev_pend <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, t;
      reset = 1'b1;
      btn_level = 4'd0;
      btn_tick = 4'd0;
      enable = 1'b1;
      mif.move_ready = 1'b1;
      step(2);
      chk("reset_valid", int'(mif.move_valid), 0);
      chk("reset_dir", int'(mif.move_dir), 0);
      chk("reset_rep", int'(mif.repeating), 0);
      reset = 1'b0;
      step(3);

      // single up tap, released after one cycle of hold
      c = cyc;
      push(2'd0, 1'b0, c + 1);
      btn_tick = 4'b0001; btn_level = 4'b0001;
      step(1);
      btn_tick = 4'd0;
      step(1);
      btn_level = 4'd0;
      step(50);

      // left+right simultaneously: left wins
      c = cyc;
      push(2'd2, 1'b0, c + 1);
      btn_tick = 4'b1100; btn_level = 4'b1100;
      step(1);
      btn_tick = 4'd0; btn_level = 4'd0;
      step(20);

      // down with consumer stalled 5 cycles, up tick ignored meanwhile
      c = cyc;
      push(2'd1, 1'b0, c + 6);
      mif.move_ready = 1'b0;
      btn_tick = 4'b0010; btn_level = 4'b0010;
      step(1);
      btn_tick = 4'd0;
      step(1);
      btn_tick = 4'b0001; btn_level = 4'd0;
      step(1);
      btn_tick = 4'd0;
      step(3);
      mif.move_ready = 1'b1;
      step(20);

      // right held 40 cycles: t, t+8, then every 4
      c = cyc;
      t = c + 1;
      push(2'd3, 1'b0, t);
      for (int k = 0; k < 8; k++) push(2'd3, 1'b1, t + HD + RP * k);
      btn_tick = 4'b1000; btn_level = 4'b1000;
      step(1);
      btn_tick = 4'd0;
      step(39);
      btn_level = 4'd0;
      step(20);

      // up held, left tick preempts during HOLD
      c = cyc;
      t = c + 1;
      push(2'd0, 1'b0, t);
      push(2'd2, 1'b0, t + 4);
      push(2'd2, 1'b1, t + 4 + HD);
      push(2'd2, 1'b1, t + 4 + HD + RP);
      btn_tick = 4'b0001; btn_level = 4'b0001;
      step(1);
      btn_tick = 4'd0;
      step(3);
      btn_tick = 4'b0100; btn_level = 4'b0101;
      step(1);
      btn_tick = 4'd0;
      step(14);
      btn_level = 4'd0;
      step(20);

      // enable dropped while stalled: pending move discarded
      mif.move_ready = 1'b0;
      btn_tick = 4'b0001; btn_level = 4'b0001;
      step(1);
      btn_tick = 4'd0;
      step(2);
      chk("pending_before_disable", int'(mif.move_valid), 1);
      enable = 1'b0;
      step(1);
      chk("disable_valid", int'(mif.move_valid), 0);
      chk("disable_rep", int'(mif.repeating), 0);
      mif.move_ready = 1'b1;
      step(2);
      enable = 1'b1;
      step(20);

      // async reset while in HOLD on right
      c = cyc;
      push(2'd3, 1'b0, c + 1);
      btn_tick = 4'b1000; btn_level = 4'b1000;
      step(1);
      btn_tick = 4'd0;
      step(3);
      chk("hold_dir_before_reset", int'(mif.move_dir), 3);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_valid", int'(mif.move_valid), 0);
      chk("async_reset_dir", int'(mif.move_dir), 0);
      chk("async_reset_rep", int'(mif.repeating), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      step(20);
      btn_level = 4'd0;
      step(5);

      chk("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
